prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Host-side counterpart of the emulator core: writes the program into instruction memory and the operands into data RAM, which the core later reads.
- Holds the core in start while loading, releases it, waits for halt and counts the executed cycles.
- Afterwards reads back a data-RAM window and streams it out, so it consumes the memories the core filled.
- Sits beside the core top level and owns the memory write/read ports whenever the core is not running.

Parameters:
- INSTR_WIDTH, 9, instruction word width.
- REG_WIDTH, 8, data word / data address width.
- IMEM_DEPTH, 512, instruction memory entries.
- DMEM_DEPTH, 256, data RAM entries.
- MAX_CYCLES, 65535, RUN timeout limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ld_valid  in  1  load beat valid.
- ld_ready  out  1  load beat accepted when valid&ready.
- ld_data  in  INSTR_WIDTH  instruction word, or byte in [7:0] during the data segment.
- ld_last  in  1  last beat of the current segment.
- dump_base  in  REG_WIDTH  first data address to read back.
- dump_len  in  REG_WIDTH+1  number of bytes to read back (0..256).
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  $clog2(IMEM_DEPTH)  instruction memory write address.
- imem_wdata  out  INSTR_WIDTH  instruction memory write data.
- dmem_we / dmem_re  out  1  data RAM write / read strobes.
- dmem_addr  out  REG_WIDTH  data RAM address.
- dmem_wdata  out  REG_WIDTH  data RAM write data.
- dmem_rdata  in  REG_WIDTH  data RAM read data, valid 1 cycle after dmem_re.
- host_own  out  1  1 = loader drives the memory ports, 0 = core drives them.
- core_start  out  1  drives core start; high holds the core in start.
- core_halt  in  1  core halt.
- out_valid  out  1  dump byte valid.
- out_ready  in  1  dump byte accepted when valid&ready.
- out_data  out  REG_WIDTH  dump byte.
- out_last  out  1  marks the final dump byte.
- cycle_count  out  16  RUN cycles counted before halt.
- done  out  1  sequence complete.
- ovf  out  1  a load segment exceeded memory depth.

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-RUN or mid-DUMP):
  - state=IDLE, all addresses=0.
  - cycle_count=0, done=0, ovf=0.
  - out_valid=0, out_last=0, out_data=0.
  - all we/re strobes=0, ld_ready=0, core_start=1, host_own=1.
- States: IDLE, LOAD_I, LOAD_D, RUN, DUMP_REQ, DUMP_CAP, DUMP_OUT, DONE.
- IDLE: ld_ready=0. The next cycle goes to LOAD_I.
- LOAD_I:
  - ld_ready=1. Each accepted beat drives imem_we=1, imem_addr=iaddr, imem_wdata=ld_data in the same cycle, then iaddr++.
  - If iaddr==IMEM_DEPTH the beat is still accepted but not written, and ovf is set (sticky).
  - An accepted beat with ld_last moves to LOAD_D.
- LOAD_D:
  - Same handshake, writing dmem at daddr with ld_data[7:0]; data bits [8] are ignored.
  - Overflow at DMEM_DEPTH is handled as in LOAD_I.
  - ld_last moves to RUN and samples dump_base and dump_len into registers.
- RUN:
  - core_start=0, host_own=0, all loader strobes=0, ld_ready=0.
  - core_halt is ignored in the first RUN cycle, because the decoder output is stale while start is being released.
  - From the 2nd RUN cycle on, cycle_count increments (saturating at 16'hFFFF) on every cycle with core_halt=0.
  - The first cycle with core_halt=1 goes to DUMP_REQ, or to DONE if the sampled dump_len==0. That cycle is not counted.
- Outside RUN, core_start=1 and host_own=1 (the core stays frozen).
- DUMP_REQ: dmem_re=1, dmem_addr=dump_base+idx (8-bit wrap-around, so 0xFF+1 reads 0x00). Goes to DUMP_CAP.
- DUMP_CAP: out_data<=dmem_rdata. Goes to DUMP_OUT.
- DUMP_OUT:
  - out_valid=1; out_data and out_last stay stable until out_ready.
  - out_last=1 when idx==dump_len-1.
  - On handshake, idx++ and go to DUMP_REQ, or to DONE after the last byte.
- DONE: done=1, cycle_count and ovf hold, all ld/out handshakes idle, until reset.
- Latency: one dump byte per 3 cycles at minimum; load writes run at one beat per cycle.

Optional Feature:
- Macro LOADER_TIMEOUT_EN.
- Defined:
  - RUN aborts when cycle_count reaches MAX_CYCLES without halt.
  - An added output port `timeout` (1 bit, reset 0) is set and stays sticky.
  - Core_start is reasserted; the FSM goes to DUMP_REQ so a partial dump still happens.
- Undefined: no timeout port; RUN waits indefinitely and cycle_count saturates.

Decomposition:
- Package loader_pkg: state enum loader_state_t and localparam widths (IADDR_W, DADDR_W, CNT_W=16).
- The optional sub-module loader_dump implements the DUMP_REQ/CAP/OUT sequencer: start pulse, base/len in, done pulse out. The main FSM keeps load and RUN.

Test Plan:
- Load 3 instructions plus 2 data bytes {0x12,0x34}, core model halts after 10 cycles, dump_base=0, dump_len=2 -> imem writes at 0..2, dmem writes 0x12@0 and 0x34@1, cycle_count=10, out stream 0x12, 0x34 with out_last on the 2nd byte, then done=1.
- Stall out_ready low for 5 cycles during DUMP_OUT -> out_valid stays high and out_data stays stable, no byte is lost or duplicated.
- dump_base=0xFF, dump_len=2 -> reads at addresses 0xFF then 0x00.
- dump_len=0 -> after halt the FSM goes straight to DONE with no out_valid.
- Send 257 data beats -> the first 256 are written, the last is accepted with no write, and ovf=1.
- Assert reset during RUN and during DUMP_OUT -> next cycle state=IDLE, core_start=1, out_valid=0, cycle_count=0. With LOADER_TIMEOUT_EN, MAX_CYCLES=20 and a core that never halts -> timeout=1 and cycle_count=20.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and widths for the program loader and its dump sequencer.
package loader_pkg;

   localparam int IADDR_W = 9;
   localparam int DADDR_W = 8;
   localparam int CNT_W   = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD_I   = 3'd1,
      LOAD_D   = 3'd2,
      RUN      = 3'd3,
      DUMP_REQ = 3'd4,
      DUMP_CAP = 3'd5,
      DUMP_OUT = 3'd6,
      DONE     = 3'd7
   } loader_state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/loader_dump.sv
// Data-RAM read-back sequencer: request, capture, then hold the byte until the sink takes it.
module loader_dump
   import loader_pkg::*;
#(
   parameter int REG_WIDTH = 8
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [REG_WIDTH-1:0] base,
   input  logic [REG_WIDTH:0]   len,
   output logic                 dmem_re,
   output logic [REG_WIDTH-1:0] dmem_addr,
   input  logic [REG_WIDTH-1:0] dmem_rdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [REG_WIDTH-1:0] out_data,
   output logic                 out_last,
   output logic                 dump_done
);

   loader_state_t        state_r;
   logic [REG_WIDTH:0]   idx_r;
   logic [REG_WIDTH:0]   idx_nxt_s;

   assign idx_nxt_s = idx_r + {{REG_WIDTH{1'b0}}, 1'b1};

   // Dump sequencer; the address wraps modulo the data RAM size.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         idx_r     <= {(REG_WIDTH+1){1'b0}};
         dmem_re   <= 1'b0;
         dmem_addr <= {REG_WIDTH{1'b0}};
         out_valid <= 1'b0;
         out_data  <= {REG_WIDTH{1'b0}};
         out_last  <= 1'b0;
         dump_done <= 1'b0;
      end else begin
         dump_done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r   <= DUMP_REQ;
                  idx_r     <= {(REG_WIDTH+1){1'b0}};
                  dmem_re   <= 1'b1;
                  dmem_addr <= base;
               end
            end
            DUMP_REQ: begin
               dmem_re <= 1'b0;
               state_r <= DUMP_CAP;
            end
            DUMP_CAP: begin
               out_data  <= dmem_rdata;
               out_valid <= 1'b1;
               out_last  <= (idx_r == len - {{REG_WIDTH{1'b0}}, 1'b1});
               state_r   <= DUMP_OUT;
            end
            DUMP_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (out_last) begin
                     dump_done <= 1'b1;
                     state_r   <= IDLE;
                  end else begin
                     idx_r     <= idx_nxt_s;
                     dmem_re   <= 1'b1;
                     dmem_addr <= base + idx_nxt_s[REG_WIDTH-1:0];
                     state_r   <= DUMP_REQ;
                  end
               end
            end
            default: begin
               state_r   <= IDLE;
               dmem_re   <= 1'b0;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Host loader: fills instruction/data memories, runs the core until halt, then dumps a data-RAM window.
// Optional macro LOADER_TIMEOUT_EN adds a RUN timeout abort and the `timeout` output.
module prog_loader
   import loader_pkg::*;
#(
   parameter int INSTR_WIDTH = 9,
   parameter int REG_WIDTH   = 8,
   parameter int IMEM_DEPTH  = 512,
   parameter int DMEM_DEPTH  = 256,
   parameter int MAX_CYCLES  = 65535
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ld_valid,
   output logic                          ld_ready,
   input  logic [INSTR_WIDTH-1:0]        ld_data,
   input  logic                          ld_last,
   input  logic [REG_WIDTH-1:0]          dump_base,
   input  logic [REG_WIDTH:0]            dump_len,
   output logic                          imem_we,
   output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
   output logic [INSTR_WIDTH-1:0]        imem_wdata,
   output logic                          dmem_we,
   output logic                          dmem_re,
   output logic [REG_WIDTH-1:0]          dmem_addr,
   output logic [REG_WIDTH-1:0]          dmem_wdata,
   input  logic [REG_WIDTH-1:0]          dmem_rdata,
   output logic                          host_own,
   output logic                          core_start,
   input  logic                          core_halt,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [REG_WIDTH-1:0]          out_data,
   output logic                          out_last,
   output logic [15:0]                   cycle_count,
   output logic                          done,
`ifdef LOADER_TIMEOUT_EN
   output logic                          timeout,
`endif
   output logic                          ovf
);

   localparam int                 IA_W    = $clog2(IMEM_DEPTH);
   localparam logic [IA_W:0]      I_LIMIT = (IA_W+1)'(IMEM_DEPTH);
   localparam logic [REG_WIDTH:0] D_LIMIT = (REG_WIDTH+1)'(DMEM_DEPTH);

   if (MAX_CYCLES < 1 || MAX_CYCLES > 65535) begin : g_max_cycles_range
      $error("MAX_CYCLES must fit the 16-bit cycle counter");
   end

   loader_state_t        state_r;
   logic [IA_W:0]        iaddr_r;
   logic [REG_WIDTH:0]   daddr_r;
   logic                 first_run_r;
   logic                 dump_start_r;
   logic [REG_WIDTH-1:0] dump_base_r;
   logic [REG_WIDTH:0]   dump_len_r;
   logic                 dump_done_s;
   logic                 dump_re_s;
   logic [REG_WIDTH-1:0] dump_addr_s;
   logic                 ld_fire_s;
   logic                 i_full_s;
   logic                 d_full_s;
   logic                 timeout_hit_s;
   logic                 run_end_s;

   // Write strobes follow the accepted beat in the same cycle; a full segment swallows beats.
   always_comb begin
      ld_fire_s = ld_valid & ld_ready;
      i_full_s  = (iaddr_r == I_LIMIT);
      d_full_s  = (daddr_r == D_LIMIT);
`ifdef LOADER_TIMEOUT_EN
      timeout_hit_s = (cycle_count == CNT_W'(MAX_CYCLES));
`else
      timeout_hit_s = 1'b0;
`endif
      run_end_s  = (state_r == RUN) & ~first_run_r & (core_halt | timeout_hit_s);
      imem_we    = 1'b0;
      imem_addr  = iaddr_r[IA_W-1:0];
      imem_wdata = ld_data;
      dmem_we    = 1'b0;
      dmem_re    = dump_re_s;
      dmem_addr  = dump_addr_s;
      dmem_wdata = ld_data[REG_WIDTH-1:0];
      if (state_r == LOAD_I) begin
         imem_we = ld_fire_s & ~i_full_s;
      end else if (state_r == LOAD_D) begin
         dmem_we   = ld_fire_s & ~d_full_s;
         dmem_addr = daddr_r[REG_WIDTH-1:0];
      end else begin
         dmem_we = 1'b0;
      end
   end

   // Main sequencer; DUMP_REQ here means the dump sequencer owns the RAM until it reports done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         iaddr_r      <= {(IA_W+1){1'b0}};
         daddr_r      <= {(REG_WIDTH+1){1'b0}};
         first_run_r  <= 1'b0;
         dump_start_r <= 1'b0;
         dump_base_r  <= {REG_WIDTH{1'b0}};
         dump_len_r   <= {(REG_WIDTH+1){1'b0}};
         ld_ready     <= 1'b0;
         core_start   <= 1'b1;
         host_own     <= 1'b1;
         cycle_count  <= 16'h0000;
         done         <= 1'b0;
         ovf          <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
         timeout      <= 1'b0;
`endif
      end else begin
         dump_start_r <= 1'b0;
         case (state_r)
            IDLE: begin
               ld_ready <= 1'b1;
               state_r  <= LOAD_I;
            end
            LOAD_I: begin
               if (ld_fire_s) begin
                  if (i_full_s) ovf <= 1'b1;
                  else          iaddr_r <= iaddr_r + (IA_W+1)'(1);
                  if (ld_last)  state_r <= LOAD_D;
               end
            end
            LOAD_D: begin
               if (ld_fire_s) begin
                  if (d_full_s) ovf <= 1'b1;
                  else          daddr_r <= daddr_r + (REG_WIDTH+1)'(1);
                  if (ld_last) begin
                     state_r     <= RUN;
                     ld_ready    <= 1'b0;
                     core_start  <= 1'b0;
                     host_own    <= 1'b0;
                     first_run_r <= 1'b1;
                     dump_base_r <= dump_base;
                     dump_len_r  <= dump_len;
                  end
               end
            end
            RUN: begin
               // Halt is stale while start is being released, so the first cycle is skipped.
               if (first_run_r) begin
                  first_run_r <= 1'b0;
               end else if (run_end_s) begin
                  core_start <= 1'b1;
                  host_own   <= 1'b1;
`ifdef LOADER_TIMEOUT_EN
                  timeout    <= ~core_halt;
`endif
                  if (dump_len_r == {(REG_WIDTH+1){1'b0}}) begin
                     state_r <= DONE;
                     done    <= 1'b1;
                  end else begin
                     state_r      <= DUMP_REQ;
                     dump_start_r <= 1'b1;
                  end
               end else begin
                  cycle_count <= sat_inc(cycle_count);
               end
            end
            DUMP_REQ: begin
               if (dump_done_s) begin
                  state_r <= DONE;
                  done    <= 1'b1;
               end
            end
            DONE: begin
               done <= 1'b1;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   loader_dump #(
      .REG_WIDTH (REG_WIDTH)
   ) u_dump (
      .clk        (clk),
      .reset      (reset),
      .start      (dump_start_r),
      .base       (dump_base_r),
      .len        (dump_len_r),
      .dmem_re    (dump_re_s),
      .dmem_addr  (dump_addr_s),
      .dmem_rdata (dmem_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .dump_done  (dump_done_s)
   );

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader with memory and core models.
module tb_prog_loader;
   import loader_pkg::*;

`ifdef LOADER_TIMEOUT_EN
   localparam int MAXC = 20;
`else
   localparam int MAXC = 65535;
`endif

   logic clk, reset, ld_valid, ld_ready, ld_last;
   logic [8:0] ld_data, dump_len;
   logic [7:0] dump_base;
   logic imem_we, dmem_we, dmem_re, host_own, core_start, core_halt;
   logic [IADDR_W-1:0] imem_addr;
   logic [8:0] imem_wdata;
   logic [DADDR_W-1:0] dmem_addr;
   logic [7:0] dmem_wdata, dmem_rdata, out_data;
   logic out_valid, out_ready, out_last, done, ovf;
   logic [15:0] cycle_count;
`ifdef LOADER_TIMEOUT_EN
   logic timeout;
`endif

   prog_loader #(.MAX_CYCLES(MAXC)) dut (
      .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_data(ld_data), .ld_last(ld_last), .dump_base(dump_base), .dump_len(dump_len),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .host_own(host_own),
      .core_start(core_start), .core_halt(core_halt), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .cycle_count(cycle_count), .done(done),
`ifdef LOADER_TIMEOUT_EN
      .timeout(timeout),
`endif
      .ovf(ovf)
   );

   int total = 0;
   int bad = 0;
   int halt_after = 10;
   int run_elapsed = 0;
   logic [7:0] dmem_m [256];
   logic [7:0] shadow [256];
   logic [7:0] dat [300];
   logic [17:0] exp_iw [$];
   logic [15:0] exp_dw [$];
   logic [7:0] exp_ra [$];
   logic [8:0] exp_out [$];
   logic [17:0] ei;
   logic [15:0] ed;
   logic [7:0] ea;
   logic [8:0] eo;
   logic rd_pend = 1'b0;
   logic [7:0] rd_addr = 8'h00;
   bit seen_valid = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core model: halts once it has run halt_after counted cycles past the ignored first one.
   always @(posedge clk) begin
      if (reset || core_start) run_elapsed <= 0;
      else run_elapsed <= run_elapsed + 1;
   end
   assign core_halt = !core_start && (run_elapsed >= halt_after + 1);

   // RAM read port: data valid one cycle after dmem_re, garbage otherwise.
   always @(posedge clk) begin
      dmem_rdata <= rd_pend ? dmem_m[rd_addr] : 8'($urandom);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitors, sampled on the falling edge.
   always @(negedge clk) begin
      rd_pend <= dmem_re;
      rd_addr <= dmem_addr;
      if (out_valid) seen_valid = 1'b1;
      if (imem_we) begin
         if (exp_iw.size() > 0) begin
            ei = exp_iw.pop_front();
            check("imem_waddr", 32'(imem_addr), 32'(ei[17:9]));
            check("imem_wdata", 32'(imem_wdata), 32'(ei[8:0]));
         end else check("imem_we_unexpected", 32'(imem_we), 32'd0);
      end
      if (dmem_we) begin
         dmem_m[dmem_addr] <= dmem_wdata;
         if (exp_dw.size() > 0) begin
            ed = exp_dw.pop_front();
            check("dmem_waddr", 32'(dmem_addr), 32'(ed[15:8]));
            check("dmem_wdata", 32'(dmem_wdata), 32'(ed[7:0]));
         end else check("dmem_we_unexpected", 32'(dmem_we), 32'd0);
      end
      if (dmem_re) begin
         if (exp_ra.size() > 0) begin
            ea = exp_ra.pop_front();
            check("dmem_raddr", 32'(dmem_addr), 32'(ea));
         end else check("dmem_re_unexpected", 32'(dmem_re), 32'd0);
      end
      if (out_valid && out_ready) begin
         if (exp_out.size() > 0) begin
            eo = exp_out.pop_front();
            check("out_data", 32'(out_data), 32'(eo[7:0]));
            check("out_last", 32'(out_last), 32'(eo[8]));
         end else check("out_unexpected", 32'(out_valid), 32'd0);
      end
   end

   task automatic do_reset();
      reset = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      exp_iw.delete(); exp_dw.delete(); exp_ra.delete(); exp_out.delete();
      seen_valid = 1'b0;
   endtask

   task automatic drive_beat(input logic [8:0] d, input logic last);
      bit ok = 1'b0;
      ld_valid = 1'b1; ld_data = d; ld_last = last;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ld_ready) begin ok = 1'b1; break; end
      end
      check("ld_ready_seen", 32'(ok), 32'd1);
      @(posedge clk);
      #1 ld_valid = 1'b0; ld_last = 1'b0;
   endtask

   task automatic load(input int ni, input int nd, input logic [7:0] base, input logic [8:0] len);
      logic [8:0] d;
      logic [7:0] a;
      dump_base = base; dump_len = len;
      for (int i = 0; i < ni; i++) begin
         d = 9'($urandom);
         if (i < 512) exp_iw.push_back({9'(i), d});
         drive_beat(d, i == ni - 1);
      end
      for (int i = 0; i < nd; i++) begin
         d = {1'($urandom), dat[i]};
         if (i < 256) begin
            exp_dw.push_back({8'(i), d[7:0]});
            shadow[i] = d[7:0];
         end
         drive_beat(d, i == nd - 1);
      end
      for (int k = 0; k < int'(len); k++) begin
         a = base + 8'(k);
         exp_ra.push_back(a);
         exp_out.push_back({k == int'(len) - 1, shadow[a]});
      end
   endtask

   task automatic finish_run(input int exp_cc, input logic exp_ovf, input bit stall);
      bit got = 1'b0;
      bit stalled = 1'b0;
      logic [7:0] hold;
      logic hl;
      if (stall) out_ready = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (stall && !stalled && out_valid) begin
            hold = out_data; hl = out_last;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               check("stall_valid", 32'(out_valid), 32'd1);
               check("stall_data", 32'(out_data), 32'(hold));
               check("stall_last", 32'(out_last), 32'(hl));
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
            stalled = 1'b1;
         end
         if (done) begin got = 1'b1; break; end
      end
      check("done_reached", 32'(got), 32'd1);
      check("cycle_count", 32'(cycle_count), 32'(exp_cc));
      check("ovf", 32'(ovf), 32'(exp_ovf));
      check("core_start_after", 32'(core_start), 32'd1);
      check("host_own_after", 32'(host_own), 32'd1);
      check("out_valid_after", 32'(out_valid), 32'd0);
      check("ld_ready_after", 32'(ld_ready), 32'd0);
      check("pending_imem", 32'(exp_iw.size()), 32'd0);
      check("pending_dmem", 32'(exp_dw.size()), 32'd0);
      check("pending_reads", 32'(exp_ra.size()), 32'd0);
      check("pending_out", 32'(exp_out.size()), 32'd0);
   endtask

   task automatic reset_pulse_checks();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_core_start", 32'(core_start), 32'd1);
      check("rst_host_own", 32'(host_own), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_cycle_count", 32'(cycle_count), 32'd0);
      check("rst_ld_ready", 32'(ld_ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
   endtask

   initial begin
      reset = 1'b1; ld_valid = 1'b0; ld_data = 9'd0; ld_last = 1'b0;
      dump_base = 8'h00; dump_len = 9'd0; out_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         dmem_m[i] = 8'($urandom);
         shadow[i] = dmem_m[i];
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_core_start", 32'(core_start), 32'd1);
      check("reset_host_own", 32'(host_own), 32'd1);
      check("reset_ld_ready", 32'(ld_ready), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_ovf", 32'(ovf), 32'd0);
      check("reset_cycle_count", 32'(cycle_count), 32'd0);
      check("reset_strobes", 32'({imem_we, dmem_we, dmem_re}), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Basic program: 3 instructions, bytes 0x12 0x34, dump both.
      halt_after = 10; dat[0] = 8'h12; dat[1] = 8'h34;
      load(3, 2, 8'h00, 9'd2);
      finish_run(10, 1'b0, 1'b0);

      // Output back-pressure during DUMP_OUT.
      do_reset();
      halt_after = 5; dat[0] = 8'h56; dat[1] = 8'h78; dat[2] = 8'h9A;
      load(2, 3, 8'h00, 9'd3);
      finish_run(5, 1'b0, 1'b1);

      // Address wrap: 0xFF then 0x00.
      do_reset();
      halt_after = 3; dat[0] = 8'hAB;
      load(1, 1, 8'hFF, 9'd2);
      finish_run(3, 1'b0, 1'b0);

      // Empty dump goes straight to DONE.
      do_reset();
      halt_after = 4; dat[0] = 8'h5A;
      load(2, 1, 8'h00, 9'd0);
      finish_run(4, 1'b0, 1'b0);
      check("len0_no_out_valid", 32'(seen_valid), 32'd0);

      // Data segment overflow: 257 beats.
      do_reset();
      halt_after = 2;
      for (int i = 0; i < 257; i++) dat[i] = 8'($urandom);
      load(1, 257, 8'h80, 9'd1);
      finish_run(2, 1'b1, 1'b0);

      // Reset in the middle of RUN.
      do_reset();
      halt_after = 1000000;
      load(2, 2, 8'h00, 9'd2);
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (!core_start) break;
      end
      check("run_entered", 32'(core_start), 32'd0);
      repeat (5) @(posedge clk);
      reset_pulse_checks();

      // Reset while a byte is held in DUMP_OUT.
      do_reset();
      halt_after = 3; dat[0] = 8'hC3; dat[1] = 8'h3C;
      out_ready = 1'b0;
      load(1, 2, 8'h00, 9'd2);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      check("dump_out_entered", 32'(out_valid), 32'd1);
      reset_pulse_checks();
      check("rst_out_data", 32'(out_data), 32'd0);

`ifdef LOADER_TIMEOUT_EN
      // Core never halts: abort at MAX_CYCLES and still dump.
      do_reset();
      halt_after = 1000000; dat[0] = 8'h77;
      load(1, 1, 8'h00, 9'd1);
      finish_run(MAXC, 1'b0, 1'b0);
      check("timeout_flag", 32'(timeout), 32'd1);
`endif

      do_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
